// File: rtl/fpga_dsp_pkg.sv
// Shared types and helpers for the FPGA-to-DSP bridge: controller states and
// the round-robin grant search used by the channel arbiter.
package fpga_dsp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned RR_MAX = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } rr_pick_t;

  // First requester strictly after ptr, wrapping within n channels.
  function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] req,
                                       input logic [3:0]        ptr,
                                       input int unsigned       n);
    rr_pick_t    p;
    int unsigned c;
    logic [3:0]  ci;
    p = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      c  = (32'(ptr) + k) % n;
      ci = 4'(c);
      if (k <= n && !p.hit && req[ci]) begin
        p.hit = 1'b1;
        p.idx = ci;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fpga_dsp_rr_arb.sv
// Round-robin arbiter: combinational grant, pointer moves to the granted
// channel only when the grant is consumed (advance).
module fpga_dsp_rr_arb
  import fpga_dsp_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned IW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   index
);

  logic [IW-1:0] ptr;
  rr_pick_t      pick;

  always_comb begin
    pick  = rr_next(16'(req), 4'(ptr), N_CH);
    index = pick.idx[IW-1:0];
    grant = '0;
    if (pick.hit) grant[index] = 1'b1;
  end

  // Pointer starts at the last channel so channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= IW'(N_CH - 1);
    else if (advance) ptr <= index;
  end

endmodule

// File: rtl/fpga_dsp_bridge.sv
// Multi-channel FPGA-to-DSP bridge: arbitrated request intake, transaction
// FIFO, and a single-outstanding DSP bus cycle with Ack/timeout completion.
module fpga_dsp_bridge
  import fpga_dsp_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_CH-1:0]    ReqValid,
  output logic [N_CH-1:0]    ReqReady,
  input  logic [N_CH-1:0]    ReqWr,
  input  logic [N_CH*AW-1:0] ReqAddr,
  input  logic [N_CH*DW-1:0] ReqData,
  output logic [N_CH-1:0]    RespValid,
  output logic [DW-1:0]      RespData,
  output logic               RespErr,
  output logic [AW-1:0]      AddrBus,
  output logic [DW-1:0]      DataOut,
  input  logic [DW-1:0]      DataIn,
  output logic               WrEn,
  output logic               Strobe,
  input  logic               Ack,
  output logic               Busy
);

  localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned NW    = $clog2(DEPTH + 1);
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  // Arbitration and intake
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gidx;
  logic            transfer;
  txn_t            push_entry;

  logic [PW-1:0]   wptr, rptr;
  logic [NW-1:0]   count;
  logic            full, empty, push, pop;
  txn_t            mem [DEPTH];

  fpga_dsp_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req    (ReqValid),
    .advance(transfer),
    .grant  (grant),
    .index  (gidx)
  );

  assign full     = (count == NW'(DEPTH));
  assign empty    = (count == '0);
  assign ReqReady = full ? '0 : grant;
  assign transfer = |(ReqValid & ReqReady);
  assign push     = transfer;

  always_comb begin
    push_entry      = '0;
    push_entry.ch   = gidx;
    push_entry.wr   = ReqWr[gidx];
    push_entry.addr = ReqAddr[gidx*AW +: AW];
    push_entry.data = ReqData[gidx*DW +: DW];
  end

  // FIFO storage carries no reset; only pointers and count define contents.
  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // DSP-side controller
  state_t        state, state_nxt;
  txn_t          cur;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] rdata;
  logic          err;
  logic          ack_ok, expire, bus_on;

  assign pop = (state == IDLE) && !empty;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_ok    = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE:   if (!empty) state_nxt = SETUP;
      SETUP:  state_nxt = STROBE;
      STROBE: begin
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (Ack) begin
          ack_ok    = 1'b1;
          state_nxt = RESP;
        end else if (TIMEOUT != 0 && tcnt == TW'(TLAST)) begin
          expire    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cur   <= '0;
      tcnt  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (pop) cur <= mem[rptr];
      if (state == SETUP)       tcnt <= '0;
      else if (state == STROBE) tcnt <= tcnt + 1'b1;
      if (ack_ok) begin
        rdata <= cur.wr ? '0 : DataIn;
        err   <= 1'b0;
      end else if (expire) begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end
  end

  assign bus_on = (state == SETUP) || (state == STROBE);

  always_comb begin
    AddrBus   = bus_on ? cur.addr : '0;
    WrEn      = bus_on && cur.wr;
    DataOut   = (bus_on && cur.wr) ? cur.data : '0;
    Strobe    = (state == STROBE);
    RespValid = '0;
    if (state == RESP) RespValid[cur.ch] = 1'b1;
    RespData  = (state == RESP) ? rdata : '0;
    RespErr   = (state == RESP) && err;
    Busy      = !empty || (state != IDLE);
  end

endmodule

// File: tb/tb_fpga_dsp_bridge.sv
// Directed bench for fpga_dsp_bridge: one instance with a 15-cycle timeout,
// one with wait-forever for the FIFO-full scenario.
module tb_fpga_dsp_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_wr;
  logic [31:0] req_addr, req_data;
  logic [7:0]  data_in;
  logic        ack;

  logic [3:0]  req_ready, resp_valid;
  logic [7:0]  resp_data, addr_bus, data_out;
  logic        resp_err, wr_en, strobe, busy;

  logic [3:0]  z_req_ready, z_resp_valid;
  logic [7:0]  z_resp_data, z_addr_bus, z_data_out;
  logic        z_resp_err, z_wr_en, z_strobe, z_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpga_dsp_bridge #(.N_CH(4), .AW(8), .DW(8), .DEPTH(4), .TIMEOUT(15)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWr(req_wr), .ReqAddr(req_addr), .ReqData(req_data),
    .RespValid(resp_valid), .RespData(resp_data), .RespErr(resp_err),
    .AddrBus(addr_bus), .DataOut(data_out), .DataIn(data_in), .WrEn(wr_en),
    .Strobe(strobe), .Ack(ack), .Busy(busy)
  );

  fpga_dsp_bridge #(.N_CH(4), .AW(8), .DW(8), .DEPTH(4), .TIMEOUT(0)) u_dut0 (
    .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid), .ReqReady(z_req_ready),
    .ReqWr(req_wr), .ReqAddr(req_addr), .ReqData(req_data),
    .RespValid(z_resp_valid), .RespData(z_resp_data), .RespErr(z_resp_err),
    .AddrBus(z_addr_bus), .DataOut(z_data_out), .DataIn(data_in), .WrEn(z_wr_en),
    .Strobe(z_strobe), .Ack(ack), .Busy(z_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    data_in = '0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; ack = 1'b0;
    #1;
    tests++; if (strobe !== 1'b0) begin fails++; $display("FAIL rst_strobe: got %b want 0", strobe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (resp_valid !== 4'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
    tests++; if (addr_bus !== 8'h00 || wr_en !== 1'b0) begin fails++; $display("FAIL rst_bus: got addr=%h wr=%b want 00/0", addr_bus, wr_en); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); req_valid = 4'b1111; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_wr = 4'b0010; req_addr[15:8] = 8'h12; req_data[15:8] = 8'hA5;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wr_ready: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    tests++; if (busy !== 1'b1 || strobe !== 1'b0) begin fails++; $display("FAIL wr_busy_idle: got busy=%b stb=%b want 1/0", busy, strobe); end
    @(negedge clk); #1;
    tests++; if (strobe !== 1'b0 || addr_bus !== 8'h12 || wr_en !== 1'b1) begin fails++; $display("FAIL wr_setup: got stb=%b addr=%h wr=%b want 0/12/1", strobe, addr_bus, wr_en); end
    @(negedge clk); #1;
    tests++; if (strobe !== 1'b1 || addr_bus !== 8'h12 || data_out !== 8'hA5 || wr_en !== 1'b1) begin fails++; $display("FAIL wr_strobe: got stb=%b addr=%h dout=%h wr=%b want 1/12/a5/1", strobe, addr_bus, data_out, wr_en); end
    @(negedge clk); #1;
    tests++; if (strobe !== 1'b1 || resp_valid !== 4'b0) begin fails++; $display("FAIL wr_wait: got stb=%b rv=%b want 1/0000", strobe, resp_valid); end
    @(negedge clk); ack = 1'b1; #1;
    tests++; if (strobe !== 1'b1 || data_out !== 8'hA5) begin fails++; $display("FAIL wr_hold: got stb=%b dout=%h want 1/a5", strobe, data_out); end
    @(negedge clk); ack = 1'b0; #1;
    tests++; if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_data !== 8'h00) begin fails++; $display("FAIL wr_resp: got rv=%b err=%b data=%h want 0010/0/00", resp_valid, resp_err, resp_data); end
    tests++; if (strobe !== 1'b0 || wr_en !== 1'b0 || addr_bus !== 8'h00) begin fails++; $display("FAIL wr_resp_bus: got stb=%b wr=%b addr=%h want 0/0/00", strobe, wr_en, addr_bus); end
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0 || resp_valid !== 4'b0) begin fails++; $display("FAIL wr_done: got busy=%b rv=%b want 0/0000", busy, resp_valid); end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_wr = 4'b0000; req_addr[7:0] = 8'h40; ack = 1'b1; data_in = 8'h3C;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rd_ready: got %b want 0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    tests++; if (resp_valid !== 4'b0) begin fails++; $display("FAIL rd_early1: got %b want 0000", resp_valid); end
    @(negedge clk); #1;
    tests++; if (strobe !== 1'b0 || addr_bus !== 8'h40 || wr_en !== 1'b0 || data_out !== 8'h00) begin fails++; $display("FAIL rd_setup: got stb=%b addr=%h wr=%b dout=%h want 0/40/0/00", strobe, addr_bus, wr_en, data_out); end
    @(negedge clk); #1;
    tests++; if (strobe !== 1'b1 || resp_valid !== 4'b0) begin fails++; $display("FAIL rd_strobe: got stb=%b rv=%b want 1/0000", strobe, resp_valid); end
    @(negedge clk); ack = 1'b0; #1;
    tests++; if (resp_valid !== 4'b0001 || resp_data !== 8'h3C || resp_err !== 1'b0) begin fails++; $display("FAIL rd_resp: got rv=%b data=%h err=%b want 0001/3c/0", resp_valid, resp_data, resp_err); end
  endtask

  task automatic test_fairness();
    int acc = 0, rsp = 0, stb = 0;
    int acc_ch[8], rsp_ch[8];
    logic [7:0] stb_addr[8];
    do_reset();
    req_wr = '0; req_addr = 32'h23222120; ack = 1'b1; data_in = 8'h5A;
    for (int cyc = 0; cyc < 120 && rsp < 8; cyc++) begin
      @(negedge clk);
      req_valid = (acc < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (req_ready != 4'b0 && acc < 8) begin
        for (int c = 0; c < 4; c++) if (req_ready[c]) acc_ch[acc] = c;
        acc++;
      end
      if (strobe && stb < 8) begin stb_addr[stb] = addr_bus; stb++; end
      if (resp_valid != 4'b0) begin
        for (int c = 0; c < 4; c++) if (resp_valid[c]) rsp_ch[rsp] = c;
        tests++; if (resp_data !== 8'h5A) begin fails++; $display("FAIL fair_data[%0d]: got %h want 5a", rsp, resp_data); end
        rsp++;
      end
    end
    ack = 1'b0;
    tests++; if (acc != 8 || rsp != 8 || stb != 8) begin fails++; $display("FAIL fair_counts: got acc=%0d rsp=%0d stb=%0d want 8/8/8", acc, rsp, stb); end
    for (int i = 0; i < 8 && i < acc && i < rsp && i < stb; i++) begin
      tests++; if (acc_ch[i] != i % 4) begin fails++; $display("FAIL fair_accept[%0d]: got ch%0d want ch%0d", i, acc_ch[i], i % 4); end
      tests++; if (rsp_ch[i] != i % 4) begin fails++; $display("FAIL fair_resp[%0d]: got ch%0d want ch%0d", i, rsp_ch[i], i % 4); end
      tests++; if (stb_addr[i] !== 8'(32'h20 + i % 4)) begin fails++; $display("FAIL fair_addr[%0d]: got %h want %h", i, stb_addr[i], 8'(32'h20 + i % 4)); end
    end
  endtask

  task automatic test_full();
    int acc = 0, rsp = 0, stb = 0, early = 0;
    logic [7:0] stb_addr[6], stb_data[6];
    do_reset();
    req_wr = 4'b0100;
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      req_valid = (acc < 6) ? 4'b0100 : 4'b0000;
      req_addr[23:16] = 8'(32'h30 + acc); req_data[23:16] = 8'(32'hC0 + acc);
      #1;
      if (z_req_ready[2] && req_valid[2]) acc++;
      if (z_resp_valid != 4'b0) early++;
    end
    tests++; if (acc != 5) begin fails++; $display("FAIL full_accepted: got %0d want 5", acc); end
    tests++; if (z_req_ready !== 4'b0 || z_busy !== 1'b1) begin fails++; $display("FAIL full_ready_busy: got rdy=%b busy=%b want 0000/1", z_req_ready, z_busy); end
    tests++; if (z_strobe !== 1'b1 || early != 0) begin fails++; $display("FAIL full_no_timeout: got stb=%b resp=%0d want 1/0", z_strobe, early); end
    for (int cyc = 0; cyc < 80 && rsp < 6; cyc++) begin
      @(negedge clk);
      ack = 1'b1;
      req_valid = (acc < 6) ? 4'b0100 : 4'b0000;
      req_addr[23:16] = 8'(32'h30 + acc); req_data[23:16] = 8'(32'hC0 + acc);
      #1;
      if (z_req_ready[2] && req_valid[2]) acc++;
      if (z_strobe && stb < 6) begin stb_addr[stb] = z_addr_bus; stb_data[stb] = z_data_out; stb++; end
      if (z_resp_valid != 4'b0) begin
        tests++; if (z_resp_valid !== 4'b0100 || z_resp_err !== 1'b0) begin fails++; $display("FAIL full_resp[%0d]: got rv=%b err=%b want 0100/0", rsp, z_resp_valid, z_resp_err); end
        rsp++;
      end
    end
    ack = 1'b0; req_valid = '0;
    tests++; if (acc != 6 || rsp != 6 || stb != 6) begin fails++; $display("FAIL full_drain: got acc=%0d rsp=%0d stb=%0d want 6/6/6", acc, rsp, stb); end
    for (int i = 0; i < stb; i++) begin
      tests++; if (stb_addr[i] !== 8'(32'h30 + i) || stb_data[i] !== 8'(32'hC0 + i)) begin fails++; $display("FAIL full_order[%0d]: got %h/%h want %h/%h", i, stb_addr[i], stb_data[i], 8'(32'h30 + i), 8'(32'hC0 + i)); end
    end
    @(negedge clk); #1;
    tests++; if (z_busy !== 1'b0) begin fails++; $display("FAIL full_idle: got busy=%b want 0", z_busy); end
  endtask

  task automatic test_timeout();
    int s = 0;
    bit got = 0;
    logic [3:0] rv = '0;
    logic [7:0] rd = '0;
    logic re = 1'b0;
    do_reset();
    data_in = 8'hFF;
    @(negedge clk); req_valid = 4'b1000; req_wr = '0; req_addr[31:24] = 8'h77;
    @(negedge clk); req_valid = '0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk); #1;
      if (strobe) s++;
      if (resp_valid != 4'b0) begin got = 1; rv = resp_valid; re = resp_err; rd = resp_data; end
    end
    tests++; if (!got || s != 15) begin fails++; $display("FAIL to_len: got resp=%0d strobe_cycles=%0d want 1/15", got, s); end
    tests++; if (rv !== 4'b1000 || re !== 1'b1 || rd !== 8'h00) begin fails++; $display("FAIL to_resp: got rv=%b err=%b data=%h want 1000/1/00", rv, re, rd); end
    s = 0; got = 0; data_in = 8'h66;
    @(negedge clk); req_valid = 4'b1000; req_addr[31:24] = 8'h78;
    @(negedge clk); req_valid = '0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk); #1;
      if (strobe) begin s++; if (s == 15) ack = 1'b1; end
      if (resp_valid != 4'b0) begin got = 1; rv = resp_valid; re = resp_err; rd = resp_data; end
    end
    ack = 1'b0;
    tests++; if (!got || s != 15) begin fails++; $display("FAIL to_edge_len: got resp=%0d strobe_cycles=%0d want 1/15", got, s); end
    tests++; if (rv !== 4'b1000 || re !== 1'b0 || rd !== 8'h66) begin fails++; $display("FAIL to_edge_resp: got rv=%b err=%b data=%h want 1000/0/66", rv, re, rd); end
  endtask

  task automatic test_reset_mid_op();
    int acc = 0, stray = 0;
    do_reset();
    req_wr = 4'b0010;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      req_valid = (acc < 3) ? 4'b0010 : 4'b0000;
      req_addr[15:8] = 8'(32'h50 + acc);
      #1;
      if (req_ready[1] && req_valid[1]) acc++;
      if (acc >= 3 && strobe) break;
    end
    req_valid = '0;
    tests++; if (acc != 3 || strobe !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_setup: got acc=%0d stb=%b busy=%b want 3/1/1", acc, strobe, busy); end
    @(negedge clk); rst_n = 1'b0; ack = 1'b1; #1;
    tests++; if (strobe !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0 || addr_bus !== 8'h00 || wr_en !== 1'b0) begin fails++; $display("FAIL mid_async: got stb=%b busy=%b rv=%b addr=%h wr=%b want 0/0/0000/00/0", strobe, busy, resp_valid, addr_bus, wr_en); end
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); #1;
      if (resp_valid != 4'b0 || strobe || busy) stray++;
    end
    ack = 1'b0;
    tests++; if (stray != 0) begin fails++; $display("FAIL mid_flushed: got %0d active cycles want 0", stray); end
    @(negedge clk); req_valid = 4'b1111; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    data_in = '0; ack = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_fairness();
    test_full();
    test_timeout();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
